// File: rtl/a_ctrl_pkg.sv
// Shared types and default constants for the burst write controller.
package a_ctrl_pkg;

    localparam int DEF_TIMEOUT_CYCLES = 500000;
    localparam int DEF_LEN_W          = 8;
    localparam int DEF_ADDR_W         = 10;
    localparam int DEF_DATA_W         = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int wd_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/a_burst_wr_ctrl_watchdog.sv
// Inactivity watchdog: counts idle enabled cycles and flags when the limit is reached.
module a_inact_watchdog
    import a_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk_ref,
    input  logic rst_n,
    input  logic en_i,
    input  logic kick_i,
    output logic expire_o
);

    localparam int            CW   = wd_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Saturates at LAST so a held expiry never wraps back to zero.
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (kick_i || !en_i) begin
            count <= '0;
        end else if (count != LAST) begin
            count <= count + CW'(1);
        end
    end

    assign expire_o = en_i && !kick_i && (count == LAST);

endmodule

// File: rtl/a_burst_wr_ctrl.sv
// Burst write controller: accepts a length/address command, then writes incoming words to memory.
// Optional inactivity timeout is compiled in with A_BURST_WR_CTRL_TIMEOUT_EN.
module a_burst_wr_ctrl
    import a_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int LEN_W          = DEF_LEN_W,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W
) (
    input  logic              clk_ref,
    input  logic              rst_n,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [LEN_W-1:0]  cmd_len_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic              data_valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic [LEN_W-1:0]  rcv_cnt_o,
    output logic              done_o,
    output logic              erreur_timeout_o,
    input  logic              clear_i
);

    state_t            state;
    state_t            next_state;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] base;
    logic              start;
    logic              accept;
    logic              last_word;
    logic              expire;

    // An abort request takes precedence over a word arriving in the same cycle.
    assign start     = (state == IDLE) && cmd_valid_i;
    assign accept    = (state == RECV) && data_valid_i && !clear_i;
    assign last_word = accept && ((rcv_cnt_o + LEN_W'(1)) == len);

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        cmd_ready_o = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    next_state = (cmd_len_i == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                if (clear_i) begin
                    next_state = IDLE;
                end else if (last_word) begin
                    next_state = DONE;
                end else if (!accept && expire) begin
                    next_state = ERR;
                end
            end
            DONE: next_state = IDLE;
            ERR: begin
                if (clear_i) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Write port and done pulse are registered so done_o lines up with the final write.
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
            rcv_cnt_o  <= '0;
            done_o     <= 1'b0;
            len        <= '0;
            base       <= '0;
        end else begin
            mem_we_o <= accept;
            done_o   <= (next_state == DONE);
            if (start) begin
                len       <= cmd_len_i;
                base      <= cmd_addr_i;
                rcv_cnt_o <= '0;
            end
            if (accept) begin
                mem_addr_o <= base + ADDR_W'(rcv_cnt_o);
                mem_data_o <= data_i;
                rcv_cnt_o  <= rcv_cnt_o + LEN_W'(1);
            end
        end
    end

`ifdef A_BURST_WR_CTRL_TIMEOUT_EN
    a_inact_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_ref (clk_ref),
        .rst_n   (rst_n),
        .en_i    (state == RECV),
        .kick_i  (start || accept),
        .expire_o(expire)
    );

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            erreur_timeout_o <= 1'b0;
        end else begin
            erreur_timeout_o <= (next_state == ERR);
        end
    end
`else
    assign expire           = 1'b0;
    assign erreur_timeout_o = 1'b0;
`endif

endmodule
